// File: rtl/pc_seq.sv
// pc_seq: IF-stage program counter sequencer with start/run/hold FSM, redirect and fetch counter.
// Optional misaligned-redirect trap to 0x80 is compiled in only when PC_SEQ_ALIGN_TRAP_EN is defined.
module pc_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        flush_o,
  output logic [31:0] fetch_cnt_o,
`ifdef PC_SEQ_ALIGN_TRAP_EN
  output logic        trap_o,
`endif
  output logic [1:0]  state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, cnt_q, cnt_d, tgt, tgt_fix;
  logic        redir, adv;
  assign redir = jump_i | branch_i;
  assign tgt = jump_i ? jump_addr_i : branch_addr_i;
  assign adv = (state_q == RUN) & ~stall_i;
`ifdef PC_SEQ_ALIGN_TRAP_EN
  logic mis;
  assign mis = tgt[1:0] != 2'b00;
  assign tgt_fix = mis ? 32'h0000_0080 : tgt;
  assign trap_o = adv & redir & mis;
`else
  assign tgt_fix = {tgt[31:2], 2'b00};
`endif
  always_comb begin
    state_d = (state_q == IDLE) ? (start_i ? RUN : IDLE) : (stall_i ? HOLD : RUN);
    pc_d = (state_q == IDLE) ? 32'h0 : adv ? (redir ? tgt_fix : pc_plus4_o) : pc_q;
    cnt_d = adv ? cnt_q + 32'd1 : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
    end
  end
  assign pc_o = pc_q;
  assign pc_plus4_o = pc_q + 32'd4;
  assign valid_o = state_q == RUN;
  assign flush_o = adv & redir;
  assign fetch_cnt_o = cnt_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed self-checking bench for pc_seq using immediate assertions.
module tb_pc_seq;
  logic        clk_i = 1'b0, rst_i, start_i, stall_i, jump_i, branch_i;
  logic [31:0] jump_addr_i, branch_addr_i, pc_o, pc_plus4_o, fetch_cnt_o;
  logic        valid_o, flush_o;
  logic [1:0]  state_o;
  int          checks = 0, errors = 0;
`ifdef PC_SEQ_ALIGN_TRAP_EN
  logic        trap_o;
`endif

  pc_seq dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .valid_o(valid_o), .flush_o(flush_o), .fetch_cnt_o(fetch_cnt_o),
`ifdef PC_SEQ_ALIGN_TRAP_EN
    .trap_o(trap_o),
`endif
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic regs(input string tag, input logic [1:0] st, input logic [31:0] pc,
                      input logic vld, input logic [31:0] cnt);
    chk({tag, ".state"}, {30'd0, state_o}, {30'd0, st});
    chk({tag, ".pc"}, pc_o, pc);
    chk({tag, ".pc4"}, pc_plus4_o, pc + 32'd4);
    chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, vld});
    chk({tag, ".cnt"}, fetch_cnt_o, cnt);
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 0; start_i = 0; stall_i = 0; jump_i = 0; branch_i = 0;
    jump_addr_i = '0; branch_addr_i = '0;
    #3;
    regs("rst", 2'd0, 32'h0, 1'b0, 32'd0);
    chk("rst.flush", {31'd0, flush_o}, 32'd0);
    @(negedge clk_i); rst_i = 1;
    tick;
    regs("idle", 2'd0, 32'h0, 1'b0, 32'd0);
    start_i = 1;
    tick; start_i = 0;
    regs("run0", 2'd1, 32'h0, 1'b1, 32'd0);
    tick; regs("run4", 2'd1, 32'h4, 1'b1, 32'd1);
    tick; regs("run8", 2'd1, 32'h8, 1'b1, 32'd2);
    branch_i = 1; branch_addr_i = 32'h40; #1;
    chk("br.flush", {31'd0, flush_o}, 32'd1);
    tick; branch_i = 0; #1;
    regs("br", 2'd1, 32'h40, 1'b1, 32'd3);
    chk("br.noflush", {31'd0, flush_o}, 32'd0);
    jump_i = 1; jump_addr_i = 32'h100; branch_i = 1; branch_addr_i = 32'h40; #1;
    chk("jb.flush", {31'd0, flush_o}, 32'd1);
    tick; jump_i = 0; branch_i = 0; #1;
    regs("jb", 2'd1, 32'h100, 1'b1, 32'd4);
    chk("jb.noflush", {31'd0, flush_o}, 32'd0);
    jump_i = 1; jump_addr_i = 32'hC;
    tick; jump_i = 0;
    regs("toC", 2'd1, 32'hC, 1'b1, 32'd5);
    stall_i = 1; branch_i = 1; branch_addr_i = 32'h40; #1;
    chk("st0.flush", {31'd0, flush_o}, 32'd0);
    tick; regs("hold1", 2'd2, 32'hC, 1'b0, 32'd5);
    chk("hold1.flush", {31'd0, flush_o}, 32'd0);
    tick; regs("hold2", 2'd2, 32'hC, 1'b0, 32'd5);
    stall_i = 0; branch_i = 0;
    tick; regs("refetch", 2'd1, 32'hC, 1'b1, 32'd5);
    tick; regs("resume", 2'd1, 32'h10, 1'b1, 32'd6);
    jump_i = 1; jump_addr_i = 32'h42; #1;
    chk("mis.flush", {31'd0, flush_o}, 32'd1);
`ifdef PC_SEQ_ALIGN_TRAP_EN
    chk("mis.trap", {31'd0, trap_o}, 32'd1);
    tick; jump_i = 0; #1;
    regs("mis", 2'd1, 32'h80, 1'b1, 32'd7);
    chk("mis.trap0", {31'd0, trap_o}, 32'd0);
    start_i = 1;
    tick; start_i = 0;
    regs("nostart", 2'd1, 32'h84, 1'b1, 32'd8);
`else
    tick; jump_i = 0;
    regs("mis", 2'd1, 32'h40, 1'b1, 32'd7);
    start_i = 1;
    tick; start_i = 0;
    regs("nostart", 2'd1, 32'h44, 1'b1, 32'd8);
`endif
    jump_i = 1; jump_addr_i = 32'hFFFF_FFFC;
    tick; jump_i = 0;
    regs("top", 2'd1, 32'hFFFF_FFFC, 1'b1, 32'd9);
    tick; regs("wrap", 2'd1, 32'h0, 1'b1, 32'd10);
    branch_i = 1; branch_addr_i = 32'h200; stall_i = 0;
    #2; rst_i = 0; #1;
    regs("midrst", 2'd0, 32'h0, 1'b0, 32'd0);
    chk("midrst.flush", {31'd0, flush_o}, 32'd0);
    branch_i = 0;
    @(negedge clk_i); rst_i = 1;
    tick; regs("idle2", 2'd0, 32'h0, 1'b0, 32'd0);
    start_i = 1;
    tick; start_i = 0;
    regs("restart", 2'd1, 32'h0, 1'b1, 32'd0);
    tick; regs("restart4", 2'd1, 32'h4, 1'b1, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start_i, input, 1, CPU start request, honoured only in IDLE.
REQ-004 SHALL have port stall_i, input, 1, hazard-detection hold request.
REQ-005 SHALL have port jump_i, input, 1, jump resolved in ID.
REQ-006 SHALL have port jump_addr_i, input, 32, jump target.
REQ-007 SHALL have port branch_i, input, 1, branch taken, resolved in ID.
REQ-008 SHALL have port branch_addr_i, input, 32, branch target.
REQ-009 SHALL have port pc_o, output, 32, current fetch address.
REQ-010 SHALL have port pc_plus4_o, output, 32, pc_o + 4, modulo 2^32.
REQ-011 SHALL have port valid_o, output, 1, pc_o is a real fetch.
REQ-012 SHALL have port flush_o, output, 1, flush the IF/ID register.
REQ-013 SHALL have port fetch_cnt_o, output, 32, count of accepted fetches.
REQ-014 SHALL have port state_o, output, 2, FSM state: IDLE=0, RUN=1, HOLD=2.

Function
REQ-015 SHALL leave IDLE only for RUN, when start_i=1; pc register loads 0, so the first RUN cycle fetches address 0.
REQ-016 SHALL ignore start_i in RUN and HOLD; restart requires reset.
REQ-017 SHALL, in IDLE, drive valid_o=0, flush_o=0, pc_o=0.
REQ-018 SHALL, in RUN, drive valid_o=1 and load next PC at each edge, by priority: stall_i (hold) > jump_i (jump_addr_i) > branch_i (branch_addr_i) > pc_plus4_o.
REQ-019 SHALL, when stall_i=1 in RUN, hold pc_o, enter HOLD, and ignore jump_i/branch_i that cycle.
REQ-020 SHALL, in HOLD, drive valid_o=0 and hold pc_o; it returns to RUN on the first edge with stall_i=0, and the refetch of the held pc_o occurs then.
REQ-021 SHALL assert flush_o combinationally in RUN when (jump_i|branch_i)&~stall_i; jump and branch together count as one redirect.
REQ-022 SHALL increment fetch_cnt_o by 1 on each edge where state is RUN and stall_i=0, wrapping 0xFFFFFFFF to 0.
REQ-023 SHALL wrap sequential PC 0xFFFFFFFC to 0x00000000 without any flag.

Reset
REQ-024 SHALL, while rst_i=0, immediately force state IDLE, pc_o=0, fetch_cnt_o=0, valid_o=0, flush_o=0, irrespective of clk_i.
REQ-025 SHALL discard any in-flight stall or redirect on reset mid-operation; start_i must be presented again after release.

Configuration
REQ-026 SHALL compile a misaligned-target trap only when PC_SEQ_ALIGN_TRAP_EN is defined.
REQ-027 SHALL, with PC_SEQ_ALIGN_TRAP_EN, on a redirect whose selected target[1:0]!=0, load pc 0x00000080 instead, assert flush_o, and pulse output trap_o (1 bit) high for that cycle; trap_o resets to 0.
REQ-028 SHALL, without PC_SEQ_ALIGN_TRAP_EN, have no trap_o port and force target[1:0] to 0 on every redirect.

Verification
REQ-029 SHALL cover: reset, then start_i pulse -> state_o 0->1, pc_o sequence 0x0, 0x4, 0x8, fetch_cnt_o counts 1, 2, 3.
REQ-030 SHALL cover: at pc_o=0x8, branch_i=1 with branch_addr_i=0x40 -> flush_o=1 that cycle, next pc_o=0x40.
REQ-031 SHALL cover: jump_i and branch_i together (0x100 / 0x40) -> next pc_o=0x100, one flush_o cycle.
REQ-032 SHALL cover: stall_i=1 for 2 cycles at pc_o=0xC with branch_i=1 -> pc_o holds 0xC, valid_o=0, no flush_o, fetch_cnt_o frozen, then resumes at 0x10.
REQ-033 SHALL cover: rst_i low mid-RUN between clock edges -> outputs zero at once; a second start_i restarts at 0x0.
REQ-034 SHALL cover: with PC_SEQ_ALIGN_TRAP_EN, jump_addr_i=0x42 -> pc_o=0x80, trap_o one-cycle pulse; without the macro, pc_o=0x40.
